// File: rtl/digit_scan_pkg.sv
// Shared display constants and helpers for the four-digit multiplexed scanner.
package digit_scan_pkg;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned DigitW    = 4;
  localparam int unsigned ValueW    = NumDigits * DigitW;

  localparam logic [NumDigits-1:0] AnIdle = 4'b1111;

  typedef enum logic [1:0] {
    Slot0,
    Slot1,
    Slot2,
    Slot3
  } slot_e;

  // A slot above digit 0 goes dark when it and every more significant nibble are zero.
  function automatic logic lz_blank(input slot_e idx, input logic [ValueW-1:0] shown);
    logic blank;
    blank = 1'b0;
    unique case (idx)
      Slot0: blank = 1'b0;
      Slot1: blank = (shown[15:4] == 12'h000);
      Slot2: blank = (shown[15:8] == 8'h00);
      Slot3: blank = (shown[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

  function automatic logic [NumDigits-1:0] an_select(input slot_e idx,
                                                     input logic [ValueW-1:0] shown,
                                                     input logic blank_lz);
    logic [NumDigits-1:0] an;
    an = AnIdle;
    if (!(blank_lz && lz_blank(idx, shown))) begin
      an[idx] = 1'b0;
    end
    return an;
  endfunction

endpackage

// File: rtl/digit_scan.sv
// Time-multiplexed four-digit hex scanner with frame-synchronous value commit
// and optional leading-zero blanking.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                 JM1222HM_clk,
  input  logic                 JM1222HM_rst_n,
  input  logic                 JM1222HM_load,
  input  logic [ValueW-1:0]    JM1222HM_value,
  input  logic                 JM1222HM_blank_lz,
  output logic                 JM1222HM_ack,
  output logic [DigitW-1:0]    JM1222HM_digit,
  output logic [NumDigits-1:0] JM1222HM_an
);

  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(REFRESH_DIV - 1);

  logic [PrescW-1:0]    presc_q;
  slot_e                idx_q;
  logic [ValueW-1:0]    shown_q;
  logic [ValueW-1:0]    pend_q;
  logic                 pend_vld_q;
  logic                 ack_q;
  logic [DigitW-1:0]    digit_q;
  logic [NumDigits-1:0] an_q;

  logic tick;
  logic frame;

  always_comb begin
    tick  = (presc_q == PrescMax);
    frame = tick && (idx_q == Slot3);
  end

  always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
    if (!JM1222HM_rst_n) begin
      presc_q    <= '0;
      idx_q      <= Slot0;
      shown_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      digit_q    <= '0;
      an_q       <= AnIdle;
    end else begin
      presc_q <= tick ? '0 : presc_q + PrescW'(1);
      if (tick) begin
        idx_q <= slot_e'(idx_q + 2'd1);
      end

      // Display only changes between frames so a value never shows half-updated.
      ack_q <= 1'b0;
      if (frame && JM1222HM_load) begin
        shown_q    <= JM1222HM_value;
        pend_vld_q <= 1'b0;
        ack_q      <= 1'b1;
      end else if (frame && pend_vld_q) begin
        shown_q    <= pend_q;
        pend_vld_q <= 1'b0;
        ack_q      <= 1'b1;
      end else if (JM1222HM_load) begin
        pend_q     <= JM1222HM_value;
        pend_vld_q <= 1'b1;
      end

      digit_q <= shown_q[{idx_q, 2'b00} +: DigitW];
      an_q    <= an_select(idx_q, shown_q, JM1222HM_blank_lz);
    end
  end

  assign JM1222HM_ack   = ack_q;
  assign JM1222HM_digit = digit_q;
  assign JM1222HM_an    = an_q;

endmodule

// File: tb/tb_digit_scan.sv
// Directed self-checking bench for digit_scan with a four-cycle slot time.
module tb_digit_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        ack;
  logic [3:0]  digit;
  logic [3:0]  an;

  int tests;
  int fails;

  digit_scan #(
    .REFRESH_DIV(4)
  ) dut (
    .JM1222HM_clk     (clk),
    .JM1222HM_rst_n   (rst_n),
    .JM1222HM_load    (load),
    .JM1222HM_value   (value),
    .JM1222HM_blank_lz(blank_lz),
    .JM1222HM_ack     (ack),
    .JM1222HM_digit   (digit),
    .JM1222HM_an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 16'(ack), 16'h0);
    chk({tag, "_digit"}, 16'(digit), 16'h0);
    chk({tag, "_an"}, 16'(an), 16'hF);
  endtask

  // One frame is 16 edges: slot s occupies edges 4s+1..4s+4 of the frame.
  // an_exp packs the expected enables as {slot3, slot2, slot1, slot0}.
  task automatic run_frame(input string name, input logic [15:0] shown_exp,
                           input logic [15:0] an_exp, input logic blank,
                           input int ld_a_at, input logic [15:0] ld_a_val,
                           input int ld_b_at, input logic [15:0] ld_b_val,
                           input int ack_at, input int n_edges);
    for (int k = 1; k <= n_edges; k++) begin
      int slot;
      slot     = (k - 1) / 4;
      blank_lz = blank;
      load     = (k == ld_a_at) || (k == ld_b_at);
      value    = (k == ld_b_at) ? ld_b_val : ((k == ld_a_at) ? ld_a_val : 16'h0000);
      @(posedge clk);
      #1;
      load = 1'b0;
      chk($sformatf("%s_e%0d_an", name, k), 16'(an), 16'(an_exp[4*slot +: 4]));
      chk($sformatf("%s_e%0d_digit", name, k), 16'(digit), 16'(shown_exp[4*slot +: 4]));
      chk($sformatf("%s_e%0d_ack", name, k), 16'(ack), 16'(k == ack_at));
      chk($sformatf("%s_e%0d_onehot", name, k), 16'($countones(~an) <= 1), 16'h1);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset_async");
    @(posedge clk);
    @(posedge clk);
    #2 chk_reset_outputs("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan, nothing loaded.
    run_frame("idle", 16'h0000, 16'h7BDE, 1'b0, 0, 16'h0, 0, 16'h0, 0, 16);
    // Load mid-frame: held back until the boundary, acked there.
    run_frame("load_pend", 16'h0000, 16'h7BDE, 1'b0, 2, 16'h12AF, 0, 16'h0, 16, 16);
    run_frame("show_12af", 16'h12AF, 16'h7BDE, 1'b0, 0, 16'h0, 0, 16'h0, 0, 16);
    // Two loads in one frame: last wins, single ack.
    run_frame("two_loads", 16'h12AF, 16'h7BDE, 1'b0, 2, 16'h1111, 7, 16'h2222, 16, 16);
    // Load on the boundary edge commits immediately.
    run_frame("show_2222", 16'h2222, 16'h7BDE, 1'b0, 16, 16'h0042, 0, 16'h0, 16, 16);
    run_frame("blank_0042", 16'h0042, 16'hFFDE, 1'b1, 3, 16'h0000, 0, 16'h0, 16, 16);
    // Partial frame with a pending load, then reset mid-frame.
    run_frame("blank_0000", 16'h0000, 16'hFFFE, 1'b1, 2, 16'hABCD, 0, 16'h0, 0, 8);

    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset_mid");
    @(posedge clk);
    #1 chk_reset_outputs("reset_mid_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Discarded value must neither ack nor appear.
    run_frame("after_rst0", 16'h0000, 16'hFFFE, 1'b1, 0, 16'h0, 0, 16'h0, 0, 16);
    run_frame("after_rst1", 16'h0000, 16'hFFFE, 1'b1, 0, 16'h0, 0, 16'h0, 0, 16);
    run_frame("after_rst2", 16'h0000, 16'h7BDE, 1'b0, 0, 16'h0, 0, 16'h0, 0, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000, meaning clock cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL provide port JM1222HM_clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port JM1222HM_rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 SHALL provide port JM1222HM_load, input, 1 bit, meaning a one-cycle strobe that presents a new value.
REQ-005 SHALL provide port JM1222HM_value, input, 16 bits, meaning four hex digits, with [3:0] as digit 0 (least significant).
REQ-006 SHALL provide port JM1222HM_blank_lz, input, 1 bit, meaning leading-zero blanking enable.
REQ-007 SHALL provide port JM1222HM_ack, output, 1 bit, meaning a one-cycle pulse when a loaded value becomes displayed.
REQ-008 SHALL provide port JM1222HM_digit, output, 4 bits, meaning the nibble to the segment decoders, with [3] driving decoder in1 and [0] driving in4.
REQ-009 SHALL provide port JM1222HM_an, output, 4 bits, meaning active-low digit enables, with an[i] selecting digit i.

Function
REQ-010 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping, asserting an internal tick on the cycle it equals REFRESH_DIV-1.
REQ-011 SHALL advance the digit index 0->1->2->3->0 on each tick, with no other state transitions.
REQ-012 SHALL hold a display register (shown) and a pending register plus a pending flag.
REQ-013 SHALL treat a frame boundary as a tick with index==3.
REQ-014 SHALL, on load, capture value into pending and set the pending flag; a later load before commit overwrites pending (last wins).
REQ-015 SHALL, at a frame boundary with pending set, copy pending into the display register, clear the flag, and pulse ack high for exactly that one cycle.
REQ-016 SHALL, on load coincident with a frame boundary, commit the newly loaded value directly, pulse ack, and leave the pending flag clear.
REQ-017 SHALL register the outputs: on each edge, digit = display nibble of the current index, and an = one-hot-low of the current index (1-cycle latency).
REQ-018 SHALL, with blank_lz=1, drive an=4'b1111 during the slot of any digit i>0 whose bits, and all bits above it, are zero; digit 0 is never blanked; digit output is unaffected.
REQ-019 SHALL, with blank_lz=0, enable every slot.
REQ-020 SHALL never drive more than one an bit low in any cycle.

Reset
REQ-021 SHALL, while JM1222HM_rst_n=0, asynchronously clear the prescaler, the index, the display and pending registers, and the pending flag; ack=0, digit=4'h0, an=4'b1111.
REQ-022 SHALL, on the first edge after reset release, drive an=4'b1110 and digit=4'h0.
REQ-023 SHALL discard a pending, uncommitted value when reset is asserted mid-frame, and SHALL never emit ack for that value.

Structure
REQ-024 SHALL place the digit count (4), the digit width (4), and the an idle value (4'b1111) in a shared display package used by the decoder stages.
REQ-025 SHALL be implemented as a single module with no sub-modules; the prescaler SHALL be sized by $clog2(REFRESH_DIV).

Verification (REFRESH_DIV=4)
REQ-026 Reset release, no load -> an sequence 1110,1101,1011,0111 repeating every 4 cycles per slot; digit=0 throughout.
REQ-027 Load 16'h12AF at cycle 2 -> the value is not shown until the frame boundary; ack is a single pulse at the boundary; digits then read F,A,2,1 in slots 0..3.
REQ-028 Loads 16'h1111 then 16'h2222 within one frame -> one ack; display=16'h2222; 16'h1111 never appears.
REQ-029 Load 16'h0042 on a boundary cycle -> ack in the same cycle; with blank_lz=1, slots 2 and 3 show an=1111 and slots 0 and 1 are enabled.
REQ-030 Value 16'h0000 with blank_lz=1 -> only slot 0 is enabled, with digit=0.
REQ-031 rst_n low mid-frame with pending set -> outputs return to reset values immediately; no ack follows; display=0 after release.
